rca_16bit: RTL and testbench

RCA_16BIT -- requirements
Module: rca_16bit

---
 rtl/rca_16bit_pkg.sv | 5 +
 rtl/rca_16bit_full_adder.sv | 11 +
 rtl/rca_16bit.sv | 68 ++++++
 tb/tb_rca_16bit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rca_16bit_pkg.sv
// Shared width constant and operand type for the 16-bit ripple-carry adder.
package rca_16bit_pkg;
  localparam int unsigned WIDTH = 16;
  typedef logic [WIDTH-1:0] operand_t;
endpackage

// File: rtl/rca_16bit_full_adder.sv
// Single-bit full-adder cell; one instance per bit of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/rca_16bit.sv
// Registered 16-bit ripple-carry adder with carry-out, signed overflow and a
// one-cycle valid pipeline. Only WIDTH = 16 is supported.
module rca_16bit
  import rca_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = rca_16bit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  // Each cell owns its own carry nets so the chain is not one self-dependent vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .sum  (sum_d[i]),
      .cout (co)
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign cout_d = g_fa[WIDTH-1].co;
  assign ovf_d  = g_fa[WIDTH-1].ci ^ g_fa[WIDTH-1].co;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rca_16bit.sv
// Scoreboard bench for rca_16bit: stimulus queues expected results, a
// monitor pops and compares them whenever out_valid is presented.
`timescale 1ns/1ps
module tb_rca_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        out_valid;

  rca_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Present one operand set for one cycle and queue its expected result.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc, input exp_t e);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Reference: 17-bit sum, overflow from operand/result sign relationship.
  task automatic send_model(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    logic [16:0] r;
    exp_t        e;
    r = {1'b0, va} + {1'b0, vb} + {16'd0, vc};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (va[15] == vb[15]) && (r[15] != va[15]);
    send(va, vb, vc, e);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {13'd0, cout, ovf, sum}, {13'd0, e.cout, e.ovf, e.sum});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  vec_t dir [9];

  initial begin
    //          a        b        cin   sum      cout  ovf
    dir[0] = {16'h00AA, 16'h000F, 1'b1, 16'h00BA, 1'b0, 1'b0};
    dir[1] = {16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    dir[2] = {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    dir[3] = {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    dir[4] = {16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    dir[5] = {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    dir[6] = {16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    dir[7] = {16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    dir[8] = {16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", {16'd0, sum}, 32'h0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, back to back
    foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].cin, {dir[i].sum, dir[i].cout, dir[i].ovf});
    @(posedge clk); #1;

    // Hold: in_valid low with changed operands must not disturb the result
    send(16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0});
    a = 16'h1234; b = 16'h0000; cin = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_sum", {16'd0, sum}, 32'h5555);
    check("hold_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("hold_sum_2", {16'd0, sum}, 32'h5555);

    // Reset mid-stream: a valid input in a reset cycle is discarded
    send(16'h7FFF, 16'h7FFF, 1'b1, {16'hFFFF, 1'b0, 1'b1});
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_sum", {16'd0, sum}, 32'h0);
    check("midrst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);

    // First input after reset appears one cycle later
    send(16'h00AA, 16'h000F, 1'b1, {16'h00BA, 1'b0, 1'b0});
    check("post_reset_valid", {31'd0, out_valid}, 32'd1);
    check("post_reset_sum", {16'd0, sum}, 32'h00BA);

    // Random back-to-back stream against the reference model
    for (int unsigned n = 0; n < 10000; n++)
      send_model(16'($urandom), 16'($urandom), 1'($urandom));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
